// File: rtl/pipe_controller_if.sv
// ID-stage decode/sequencing bundle between the IF/ID-ID/EX glue (master)
// and pipe_controller (slave).
interface pipe_controller_if;
  logic [6:0] Opcode;
  logic [6:0] Funct7;
  logic       InstrValid;
  logic [4:0] ID_Rs1;
  logic [4:0] ID_Rs2;
  logic [4:0] EX_Rd;
  logic       EX_MemRead;
  logic       EX_Redirect;

  logic       ALUSrc;
  logic       MemtoReg;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       Branch;
  logic       Jal;
  logic       Jalr;
  logic       Halt;
  logic       MulDiv;
  logic [1:0] ALUOp;
  logic       PCWrite;
  logic       IFIDWrite;
  logic       IFIDFlush;
  logic       IDEXBubble;
  logic       MulDivBusy;
  logic       Halted;

  modport master (
    output Opcode, Funct7, InstrValid, ID_Rs1, ID_Rs2, EX_Rd, EX_MemRead, EX_Redirect,
    input  ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jal, Jalr, Halt, MulDiv,
    input  ALUOp, PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulDivBusy, Halted
  );

  modport slave (
    input  Opcode, Funct7, InstrValid, ID_Rs1, ID_Rs2, EX_Rd, EX_MemRead, EX_Redirect,
    output ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jal, Jalr, Halt, MulDiv,
    output ALUOp, PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulDivBusy, Halted
  );
endinterface

// File: rtl/pipe_controller.sv
// ID-stage decoder and pipeline sequencer: load-use stall, redirect flush,
// multi-cycle mul/div freeze and halt drain into a sticky halted state.
module pipe_controller #(
  parameter int MULDIV_EN    = 1,
  parameter int MULDIV_LAT   = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_controller_if.slave bus
);
  localparam int CNT_MAX = (MULDIV_LAT > DRAIN_CYCLES) ? MULDIV_LAT : DRAIN_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  typedef enum logic [1:0] {RUN, MULDIV, DRAIN, HALTED} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jal, Jalr, Halt, MulDiv, ALUOp}
  logic [11:0] ctrl_raw;
  logic [11:0] ctrl_out;
  logic        rs1_used, rs2_used;
  logic        hazard, redirect, bubble, issue;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, busy, halted;

  always_comb begin
    ctrl_raw = '0;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (bus.Opcode)
      OP_R: begin
        ctrl_raw = 12'b0010_0000_0010;
        ctrl_raw[2] = (MULDIV_EN != 0) && (bus.Funct7 == 7'b0000001);
        rs2_used = 1'b1;
      end
      OP_I:    ctrl_raw = 12'b1010_0000_0010;
      OP_LW:   ctrl_raw = 12'b1111_0000_0000;
      OP_SW: begin
        ctrl_raw = 12'b1000_1000_0000;
        rs2_used = 1'b1;
      end
      OP_BR: begin
        ctrl_raw = 12'b0000_0100_0001;
        rs2_used = 1'b1;
      end
      OP_LUI: begin
        ctrl_raw = 12'b1010_0000_0011;
        rs1_used = 1'b0;
      end
      OP_JAL: begin
        ctrl_raw = 12'b0010_0010_0000;
        rs1_used = 1'b0;
      end
      OP_JALR: ctrl_raw = 12'b1010_0001_0011;
      OP_HALT: ctrl_raw = 12'b0000_0000_1000;
      default: ctrl_raw = '0;
    endcase
  end

  always_comb begin
    hazard   = bus.InstrValid && bus.EX_MemRead && (bus.EX_Rd != '0) &&
               ((rs1_used && (bus.EX_Rd == bus.ID_Rs1)) ||
                (rs2_used && (bus.EX_Rd == bus.ID_Rs2)));
    redirect = (state_q == RUN) && bus.EX_Redirect;
    bubble   = (state_q != RUN) || redirect || hazard;
    issue    = rst_n && bus.InstrValid && !bubble;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (issue && ctrl_raw[2]) begin
          state_d = MULDIV;
          cnt_d   = CW'(MULDIV_LAT);
        end else if (issue && ctrl_raw[3]) begin
          state_d = DRAIN;
          cnt_d   = CW'(DRAIN_CYCLES);
        end
      end
      MULDIV: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RUN;
      end
      DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = HALTED;
      end
      default: state_d = HALTED;
    endcase
  end

  // Reset forces the frozen/bubble output pattern before the state register clears.
  always_comb begin
    ctrl_out    = '0;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;
    busy        = 1'b0;
    halted      = 1'b0;
    if (rst_n) begin
      case (state_q)
        RUN: begin
          ctrl_out    = ctrl_raw & {12{issue}};
          pc_write    = redirect || !hazard;
          ifid_write  = redirect || !hazard;
          ifid_flush  = redirect;
          idex_bubble = bubble;
        end
        MULDIV:  busy   = 1'b1;
        DRAIN:   ;
        default: halted = 1'b1;
      endcase
    end
  end

  assign {bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead, bus.MemWrite,
          bus.Branch, bus.Jal, bus.Jalr, bus.Halt, bus.MulDiv, bus.ALUOp} = ctrl_out;
  assign bus.PCWrite    = pc_write;
  assign bus.IFIDWrite  = ifid_write;
  assign bus.IFIDFlush  = ifid_flush;
  assign bus.IDEXBubble = idex_bubble;
  assign bus.MulDivBusy = busy;
  assign bus.Halted     = halted;
endmodule

// File: tb/tb_pipe_controller.sv
// Randomized bench for pipe_controller with a behavioural model, comparing an
// M-enabled and an M-disabled instance every cycle plus directed literal checks.
module tb_pipe_controller;
  localparam int LAT   = 4;
  localparam int DRAIN = 3;

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] HALT = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opc, f7;
  logic       valid, exmr, redir;
  logic [4:0] rs1, rs2, exrd;

  int vectors = 0;
  int errors  = 0;

  pipe_controller_if ifa ();
  pipe_controller_if ifb ();

  assign ifa.Opcode = opc;   assign ifb.Opcode = opc;
  assign ifa.Funct7 = f7;    assign ifb.Funct7 = f7;
  assign ifa.InstrValid = valid; assign ifb.InstrValid = valid;
  assign ifa.ID_Rs1 = rs1;   assign ifb.ID_Rs1 = rs1;
  assign ifa.ID_Rs2 = rs2;   assign ifb.ID_Rs2 = rs2;
  assign ifa.EX_Rd = exrd;   assign ifb.EX_Rd = exrd;
  assign ifa.EX_MemRead = exmr;   assign ifb.EX_MemRead = exmr;
  assign ifa.EX_Redirect = redir; assign ifb.EX_Redirect = redir;

  pipe_controller #(.MULDIV_EN(1), .MULDIV_LAT(LAT), .DRAIN_CYCLES(DRAIN)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  pipe_controller #(.MULDIV_EN(0), .MULDIV_LAT(LAT), .DRAIN_CYCLES(DRAIN)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  logic [17:0] got [2];
  assign got[0] = {ifa.ALUSrc, ifa.MemtoReg, ifa.RegWrite, ifa.MemRead, ifa.MemWrite,
                   ifa.Branch, ifa.Jal, ifa.Jalr, ifa.Halt, ifa.MulDiv, ifa.ALUOp,
                   ifa.PCWrite, ifa.IFIDWrite, ifa.IFIDFlush, ifa.IDEXBubble,
                   ifa.MulDivBusy, ifa.Halted};
  assign got[1] = {ifb.ALUSrc, ifb.MemtoReg, ifb.RegWrite, ifb.MemRead, ifb.MemWrite,
                   ifb.Branch, ifb.Jal, ifb.Jalr, ifb.Halt, ifb.MulDiv, ifb.ALUOp,
                   ifb.PCWrite, ifb.IFIDWrite, ifb.IFIDFlush, ifb.IDEXBubble,
                   ifb.MulDivBusy, ifb.Halted};

  // Model state: frozen cycles still owed by mul/div or drain, and the halt latch.
  int m_busy [2]  = '{0, 0};
  int m_drain [2] = '{0, 0};
  bit m_halt [2]  = '{1'b0, 1'b0};

  // Control word {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jal,Jalr,Halt,MulDiv,ALUOp}
  function automatic logic [11:0] decode(input logic [6:0] o, input logic [6:0] f, input bit en);
    case (o)
      7'b0110011: return {10'b0010000000 | {9'b0, (en && f == 7'b0000001)}, 2'b10};
      7'b0010011: return 12'b101000000010;
      7'b0000011: return 12'b111100000000;
      7'b0100011: return 12'b100010000000;
      7'b1100011: return 12'b000001000001;
      7'b0110111: return 12'b101000000011;
      7'b1101111: return 12'b001000100000;
      7'b1100111: return 12'b101000010011;
      7'b1111111: return 12'b000000001000;
      default:    return 12'b0;
    endcase
  endfunction

  function automatic logic [17:0] model(input int d);
    logic [11:0] c;
    bit rs1u, rs2u, hz;
    if (rst_n !== 1'b1) return 18'b000000000000_000100;
    if (m_busy[d] > 0 || m_drain[d] > 0 || m_halt[d])
      return {12'b0, 4'b0001, (m_busy[d] > 0), m_halt[d]};
    c    = decode(opc, f7, d == 0);
    rs1u = (opc != 7'b0110111) && (opc != 7'b1101111);
    rs2u = (opc == 7'b0110011) || (opc == 7'b0100011) || (opc == 7'b1100011);
    hz   = valid && exmr && exrd != 0 && ((rs1u && exrd == rs1) || (rs2u && exrd == rs2));
    if (redir) return {12'b0, 4'b1111, 2'b00};
    if (hz)    return {12'b0, 4'b0001, 2'b00};
    if (!valid) c = '0;
    return {c, 4'b1100, 2'b00};
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [17:0] e;
      int nb, nd;
      bit nh;
      e  = model(d);
      nb = m_busy[d];
      nd = m_drain[d];
      nh = m_halt[d];
      if (rst_n !== 1'b1) begin
        nb = 0; nd = 0; nh = 1'b0;
      end else if (nb > 0) begin
        nb = nb - 1;
      end else if (nd > 0) begin
        nd = nd - 1;
        if (nd == 0) nh = 1'b1;
      end else if (!nh) begin
        if (e[8]) nb = LAT;
        if (e[9]) nd = DRAIN;
      end
      m_busy[d]  <= nb;
      m_drain[d] <= nd;
      m_halt[d]  <= nh;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [17:0] e;
      e = model(d);
      vectors++;
      if (got[d] !== e) begin
        errors++;
        $display("FAIL model_dut%0d t=%0t got=%b expected=%b", d, $time, got[d], e);
      end
    end
  end

  task automatic chk(input string name, input logic [1:0] g, input logic [1:0] e);
    vectors++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, g, e);
    end
  endtask

  task automatic set_in(input logic [6:0] o, input logic [6:0] f, input logic v,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] rd,
                        input logic mr, input logic rdr, input logic rs);
    @(posedge clk);
    #1;
    opc = o; f7 = f; valid = v; rs1 = a; rs2 = b; exrd = rd;
    exmr = mr; redir = rdr; rst_n = rs;
    #3;
  endtask

  task automatic set_rand(input logic rs);
    logic [6:0] ops [9];
    logic [6:0] o;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b1101111, 7'b1100111, 7'b1111111};
    o = ($urandom_range(0, 10) > 8) ? 7'($urandom) : ops[$urandom_range(0, 8)];
    if (o == HALT && $urandom_range(0, 3) != 0) o = ADD;
    set_in(o, ($urandom_range(0, 1) == 1) ? 7'b0000001 : 7'($urandom),
           ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), rs);
  endtask

  initial begin
    opc = ADD; f7 = '0; valid = 1'b0; rs1 = '0; rs2 = '0; exrd = '0;
    exmr = 1'b0; redir = 1'b0; rst_n = 1'b0;

    set_in(ADD, 7'h00, 1, 1, 5, 5, 1, 0, 0);
    chk("rst_pcwrite", ifa.PCWrite, 0);
    chk("rst_bubble", ifa.IDEXBubble, 1);
    chk("rst_regwrite", ifa.RegWrite, 0);
    set_in(ADD, 7'h00, 1, 1, 5, 5, 1, 0, 0);

    set_in(ADD, 7'h00, 1, 1, 5, 5, 1, 0, 1);
    chk("lu_pcwrite", ifa.PCWrite, 0);
    chk("lu_ifidwrite", ifa.IFIDWrite, 0);
    chk("lu_bubble", ifa.IDEXBubble, 1);
    chk("lu_regwrite", ifa.RegWrite, 0);
    set_in(ADD, 7'h00, 1, 1, 5, 0, 1, 0, 1);
    chk("x0_pcwrite", ifa.PCWrite, 1);
    chk("x0_regwrite", ifa.RegWrite, 1);

    set_in(LUI, 7'h00, 1, 5, 0, 5, 1, 0, 1);
    chk("lui_pcwrite", ifa.PCWrite, 1);
    chk("lui_aluop", ifa.ALUOp, 2'b11);
    chk("lui_alusrc", ifa.ALUSrc, 1);
    chk("lui_regwrite", ifa.RegWrite, 1);

    set_in(ADD, 7'h00, 1, 1, 5, 5, 1, 1, 1);
    chk("rd_flush", ifa.IFIDFlush, 1);
    chk("rd_bubble", ifa.IDEXBubble, 1);
    chk("rd_pcwrite", ifa.PCWrite, 1);
    set_in(HALT, 7'h00, 1, 0, 0, 0, 0, 1, 1);
    chk("rdh_halt", ifa.Halt, 0);
    chk("rdh_flush", ifa.IFIDFlush, 1);
    set_in(ADD, 7'h00, 1, 1, 2, 0, 0, 0, 1);
    chk("rdh_run_pcwrite", ifa.PCWrite, 1);
    chk("rdh_run_bubble", ifa.IDEXBubble, 0);

    set_in(ADD, 7'h01, 1, 1, 2, 0, 0, 0, 1);
    chk("mul_a_muldiv", ifa.MulDiv, 1);
    chk("mul_a_pcwrite", ifa.PCWrite, 1);
    chk("mul_b_muldiv", ifb.MulDiv, 0);
    chk("mul_b_regwrite", ifb.RegWrite, 1);
    for (int i = 0; i < LAT; i++) begin
      set_in(ADD, 7'h00, 1, 1, 2, 0, 0, 0, 1);
      chk("mul_busy", ifa.MulDivBusy, 1);
      chk("mul_frozen_pcwrite", ifa.PCWrite, 0);
      chk("mul_b_pcwrite", ifb.PCWrite, 1);
    end
    set_in(ADD, 7'h00, 1, 1, 2, 0, 0, 0, 1);
    chk("mul_done_busy", ifa.MulDivBusy, 0);
    chk("mul_done_pcwrite", ifa.PCWrite, 1);
    chk("mul_done_regwrite", ifa.RegWrite, 1);

    set_in(ADD, 7'h01, 1, 1, 2, 0, 0, 0, 1);
    set_in(ADD, 7'h00, 1, 1, 2, 0, 0, 0, 1);
    set_in(ADD, 7'h00, 1, 1, 2, 0, 0, 0, 0);
    chk("rstmul_busy", ifa.MulDivBusy, 0);
    chk("rstmul_bubble", ifa.IDEXBubble, 1);
    set_in(ADD, 7'h00, 1, 1, 2, 0, 0, 0, 1);
    chk("rstmul_rel_busy", ifa.MulDivBusy, 0);
    chk("rstmul_rel_pcwrite", ifa.PCWrite, 1);
    chk("rstmul_rel_regwrite", ifa.RegWrite, 1);

    set_in(HALT, 7'h00, 1, 0, 0, 0, 0, 0, 1);
    chk("halt_issue", ifa.Halt, 1);
    chk("halt_issue_pcwrite", ifa.PCWrite, 1);
    for (int i = 0; i < DRAIN; i++) begin
      set_in(ADD, 7'h00, 1, 1, 2, 0, 0, 0, 1);
      chk("drain_pcwrite", ifa.PCWrite, 0);
      chk("drain_halted", ifa.Halted, 0);
      chk("drain_busy", ifa.MulDivBusy, 0);
    end
    for (int i = 0; i < 22; i++) begin
      set_rand(1'b1);
      chk("halted_sticky", ifa.Halted, 1);
      chk("halted_pcwrite", ifa.PCWrite, 0);
    end
    set_in(ADD, 7'h00, 1, 1, 2, 0, 0, 0, 0);
    chk("rsthalt_halted", ifa.Halted, 0);
    set_in(ADD, 7'h00, 1, 1, 2, 0, 0, 0, 1);
    chk("rsthalt_rel_halted", ifa.Halted, 0);
    chk("rsthalt_rel_regwrite", ifa.RegWrite, 1);
    chk("rsthalt_rel_pcwrite", ifa.PCWrite, 1);

    for (int i = 0; i < 3000; i++)
      set_rand(($urandom_range(0, 59) != 0) ? 1'b1 : 1'b0);

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/pipe_controller.md
# pipe_controller

Next-generation instruction decoder and pipeline sequencer for the 5-stage RISC-V core. It decodes the ID-stage opcode into the same control set as the current decoder. It also owns pipeline sequencing:
- load-use stall
- branch/jump flush
- optional multi-cycle M-extension stall (parametrised latency)
- halt drain to a sticky halted state

It sits between the IF/ID register and the ID/EX register and drives the PC and IF/ID write enables.

## Interface
Parameters:
- MULDIV_EN, 1: 1 enables M-extension decode and stall; 0 decodes Funct7=0000001 R-type as plain R-type.
- MULDIV_LAT, 4: freeze cycles after a mul/div issues (≥1).
- DRAIN_CYCLES, 3: cycles after halt issue until Halted (≥1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- Opcode  in  7  ID-stage opcode
- Funct7  in  7  ID-stage funct7
- InstrValid  in  1  IF/ID holds a valid instruction
- ID_Rs1, ID_Rs2  in  5  ID source registers
- EX_Rd  in  5  destination register of the instruction in EX
- EX_MemRead  in  1  instruction in EX is a load
- EX_Redirect  in  1  taken branch/JAL/JALR resolved in EX
- ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jal, Jalr, Halt, MulDiv  out  1  gated ID controls
- ALUOp  out  2  00 LW/SW, 01 BR, 10 R/I, 11 LUI/JALR
- PCWrite  out  1  PC register enable
- IFIDWrite  out  1  IF/ID enable
- IFIDFlush  out  1  zero IF/ID next edge
- IDEXBubble  out  1  inject NOP into ID/EX
- MulDivBusy  out  1  FSM in MULDIV
- Halted  out  1  sticky halt

## Operation
- Opcode encodings:

  | Class | Opcode |
  |---|---|
  | R | 0110011 |
  | I | 0010011 |
  | LW | 0000011 |
  | SW | 0100011 |
  | BR | 1100011 |
  | LUI | 0110111 |
  | JAL | 1101111 |
  | JALR | 1100111 |
  | HALT | 1111111 |

- Raw decode is identical to the existing controller. Additionally, MulDiv = MULDIV_EN & R-type & Funct7==0000001.
- Gating: every control output is raw decode AND Issue, where Issue = InstrValid & ~IDEXBubble & state==RUN.
- Load-use hazard: EX_MemRead & EX_Rd≠0 & one of:
  - EX_Rd==ID_Rs1, with rs1 used by all except LUI and JAL
  - EX_Rd==ID_Rs2, with rs2 used by R, SW and BR

  In this case InstrValid=1 and the hazard drives PCWrite=0, IFIDWrite=0, IDEXBubble=1.
- Redirect (RUN only): IFIDFlush=1, IDEXBubble=1, PCWrite=1. Redirect beats hazard, mul/div issue and halt; the ID instruction is discarded.
- State machine (state and counter registered, counter width $clog2(max(MULDIV_LAT,DRAIN_CYCLES)+1)):
  - RUN:
    - Issue & MulDiv → MULDIV, counter loaded with MULDIV_LAT.
    - Issue & Halt → DRAIN, counter loaded with DRAIN_CYCLES.
    - Otherwise stay in RUN.
  - MULDIV: PCWrite=0, IFIDWrite=0, IDEXBubble=1, MulDivBusy=1. Counter decrements each cycle; counter==1 → RUN.
  - DRAIN: same freeze as MULDIV with MulDivBusy=0. Counter decrements; counter==1 → HALTED.
  - HALTED: freeze, Halted=1. Only reset leaves this state.
- EX_Redirect is ignored outside RUN, since no older control-flow instruction can exist then.
- MULDIV_EN=0: MulDiv=0 and no MULDIV entry.
- Default (RUN, no event): PCWrite=1, IFIDWrite=1, flush/bubble 0.

## Timing
- Decode, hazard and redirect responses are combinational in the same cycle.
- State changes occur on the clk edge.
- Mul/div:
  - Issue cycle: PCWrite=1, so the next instruction is fetched.
  - Then exactly MULDIV_LAT frozen cycles.
  - RUN resumes on the following cycle.
- Halt:
  - Halt=1 in the issue cycle.
  - Then DRAIN_CYCLES frozen cycles.
  - Halted=1 from the next cycle onward.
- Reset, rst_n=0 sampled at an edge:
  - state goes to RUN and counter to 0, from any state, including mid-MULDIV and mid-DRAIN.
  - While rst_n=0, outputs are forced combinationally: all controls 0, PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0, MulDivBusy=0, Halted=0.
- Reset and a simultaneous event in the same cycle: reset wins.
- Bubbled or flushed cycles never start MULDIV or DRAIN.

## Test plan
- Load-use stall: EX_MemRead=1, EX_Rd=5, ID is ADD with Rs2=5 → one cycle with PCWrite=0, IFIDWrite=0, IDEXBubble=1, RegWrite=0. With EX_Rd=0 instead → no stall.
- LUI with Rs1 field=5 against a load writing x5 → no stall, ALUOp=11, ALUSrc=1, RegWrite=1.
- Redirect plus hazard in the same cycle → IFIDFlush=1, IDEXBubble=1, PCWrite=1. A HALT in ID during a redirect → state stays RUN and Halt=0.
- MULDIV_LAT=4, MUL issued → MulDiv=1 in the issue cycle, then exactly 4 cycles of MulDivBusy=1 with PCWrite=0, then RUN. With MULDIV_EN=0 the same instruction → MulDiv=0 and no stall.
- HALT with DRAIN_CYCLES=3 → Halt=1 for one cycle, 3 frozen cycles, then Halted=1 held for 20 or more cycles regardless of inputs.
- rst_n=0 at cycle 2 of MULDIV and again while HALTED → next cycle in RUN, Halted=0, MulDivBusy=0, and normal decode resumes after release.
